mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder.sv | 141 ++++++++++++++
 tb/tb_mem_responder.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// Line-granular memory responder for a cache: accepts refill (read) and
// writeback (write) line requests, waits a fixed latency, then streams beats.
module mem_responder #(
    parameter int MEM_WORDS_LOG2 = 10,
    parameter int LINE_WORDS     = 4,
    parameter int LATENCY        = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] wdata,
    input  logic        wvalid,
    output logic        wready,
    output logic [31:0] rdata,
    output logic        rvalid,
    input  logic        rready,
    output logic        rlast,
    output logic        wdone,
    output logic        busy
);

    localparam int BEAT_W = $clog2(LINE_WORDS);
    localparam int LAT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam int DEPTH  = 1 << MEM_WORDS_LOG2;

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_WORDS - 1);
    localparam logic [LAT_W-1:0]  LAT_LOAD  = LAT_W'(LATENCY - 1);

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        RBURST,
        WBURST,
        WDONE
    } state_t;

    state_t                    state, state_nxt;
    logic [BEAT_W-1:0]         beat, beat_nxt;
    logic [LAT_W-1:0]          lat_cnt, lat_cnt_nxt;
    logic                      is_write, is_write_nxt;
    logic [MEM_WORDS_LOG2-1:0] line_base, line_base_nxt;
    logic [MEM_WORDS_LOG2-1:0] word_idx;
    logic                      mem_we;
    logic [31:0]               mem [DEPTH];

    // Address bits above the storage size and below the line boundary are dropped.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{req_addr[31:MEM_WORDS_LOG2+2], req_addr[BEAT_W+1:0]};

    // Line base has its low beat bits cleared, so the add never carries past the line.
    assign word_idx = line_base + MEM_WORDS_LOG2'(beat);

    // NOTE: every always_comb output gets a default first; a missing branch would otherwise infer a latch.
    always_comb begin
        state_nxt     = state;
        beat_nxt      = beat;
        lat_cnt_nxt   = lat_cnt;
        is_write_nxt  = is_write;
        line_base_nxt = line_base;
        mem_we        = 1'b0;

        case (state)
            IDLE: begin
                if (req_valid) begin
                    is_write_nxt  = req_write;
                    line_base_nxt = {req_addr[MEM_WORDS_LOG2+1:BEAT_W+2], {BEAT_W{1'b0}}};
                    lat_cnt_nxt   = LAT_LOAD;
                    beat_nxt      = '0;
                    state_nxt     = WAIT;
                end
            end
            WAIT: begin
                if (lat_cnt == '0) begin
                    state_nxt = is_write ? WBURST : RBURST;
                end else begin
                    lat_cnt_nxt = lat_cnt - 1'b1;
                end
            end
            RBURST: begin
                if (rready) begin
                    beat_nxt = beat + 1'b1;
                    if (beat == LAST_BEAT) begin
                        state_nxt = IDLE;
                    end
                end
            end
            WBURST: begin
                if (wvalid) begin
                    mem_we   = 1'b1;
                    beat_nxt = beat + 1'b1;
                    if (beat == LAST_BEAT) begin
                        state_nxt = WDONE;
                    end
                end
            end
            WDONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            beat      <= '0;
            lat_cnt   <= '0;
            is_write  <= 1'b0;
            line_base <= '0;
        end else begin
            state     <= state_nxt;
            beat      <= beat_nxt;
            lat_cnt   <= lat_cnt_nxt;
            is_write  <= is_write_nxt;
            line_base <= line_base_nxt;
        end
    end

    // NOTE: storage has no reset; contents survive rst, which only blocks the write in that cycle.
    always_ff @(posedge clk) begin
        if (mem_we && !rst) begin
            mem[word_idx] <= wdata;
        end
    end

    // All outputs decode from state and registered counters only.
    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign wready    = (state == WBURST);
    assign wdone     = (state == WDONE);
    assign rvalid    = (state == RBURST);
    assign rlast     = (state == RBURST) && (beat == LAST_BEAT);
    assign rdata     = (state == RBURST) ? mem[word_idx] : 32'h0;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: randomized line traffic compared
// against a word-array model addressed by line number arithmetic.
module tb_mem_responder;

    localparam int MWL   = 10;
    localparam int LW    = 4;
    localparam int LAT   = 3;
    localparam int WORDS = 1 << MWL;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [31:0] rdata;
    logic        rvalid;
    logic        rready = 1'b0;
    logic        rlast;
    logic        wdone;
    logic        busy;

    int errors = 0;
    int checks = 0;

    logic [31:0] ref_mem [WORDS];
    bit          stall_pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

    mem_responder #(
        .MEM_WORDS_LOG2(MWL),
        .LINE_WORDS    (LW),
        .LATENCY       (LAT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_write(req_write),
        .req_addr (req_addr),
        .wdata    (wdata),
        .wvalid   (wvalid),
        .wready   (wready),
        .rdata    (rdata),
        .rvalid   (rvalid),
        .rready   (rready),
        .rlast    (rlast),
        .wdone    (wdone),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    // Storage word for a beat: line number times line length, plus beat, modulo depth.
    function automatic int unsigned widx(input logic [31:0] addr, input int beat);
        int unsigned line;
        line = addr / (4 * LW);
        return (line * LW + beat) % WORDS;
    endfunction

    // Entered just after a negedge with the DUT idle.
    task automatic write_line(input logic [31:0] addr, input logic [31:0] d [LW], input bit rand_valid);
        int k;
        int b;
        int guard;
        bit wv;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL wr_start_ready addr=%h: got %b want 1", addr, req_ready);
        end
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = addr;
        @(negedge clk);
        req_valid = 1'b0;
        req_write = 1'($urandom_range(0, 1));
        req_addr  = $urandom();
        k = 0;
        while (wready !== 1'b1 && k < 4 * LAT + 8) begin
            checks++;
            if (busy !== 1'b1 || req_ready !== 1'b0 || rvalid !== 1'b0 || wdone !== 1'b0) begin
                errors++;
                $display("FAIL wr_wait addr=%h: busy=%b req_ready=%b rvalid=%b wdone=%b want 1,0,0,0",
                         addr, busy, req_ready, rvalid, wdone);
            end
            @(negedge clk);
            k++;
        end
        checks++;
        if (k != LAT) begin
            errors++;
            $display("FAIL wr_latency addr=%h: got %0d want %0d", addr, k, LAT);
        end
        b = 0;
        guard = 0;
        while (b < LW && guard < 64) begin
            wv     = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
            wvalid = wv;
            wdata  = wv ? d[b] : $urandom();
            checks++;
            if (wready !== 1'b1 || wdone !== 1'b0 || rvalid !== 1'b0) begin
                errors++;
                $display("FAIL wr_beat addr=%h beat=%0d: wready=%b wdone=%b rvalid=%b want 1,0,0",
                         addr, b, wready, wdone, rvalid);
            end
            @(negedge clk);
            guard++;
            if (wv) begin
                ref_mem[widx(addr, b)] = d[b];
                b++;
            end
        end
        // Stray beat offered after the burst must be ignored.
        wvalid = 1'b1;
        wdata  = $urandom();
        checks++;
        if (b != LW) begin
            errors++;
            $display("FAIL wr_beats addr=%h: got %0d want %0d", addr, b, LW);
        end
        checks++;
        if (wdone !== 1'b1 || wready !== 1'b0 || req_ready !== 1'b0) begin
            errors++;
            $display("FAIL wr_wdone addr=%h: wdone=%b wready=%b req_ready=%b want 1,0,0",
                     addr, wdone, wready, req_ready);
        end
        @(negedge clk);
        wvalid = 1'b0;
        checks++;
        if (wdone !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL wr_end addr=%h: wdone=%b req_ready=%b busy=%b want 0,1,0",
                     addr, wdone, req_ready, busy);
        end
    endtask

    // mode 0: rready always high, 1: random, 2: fixed stall pattern.
    task automatic read_line(input logic [31:0] addr, input int mode, input bit hold);
        int k;
        int b;
        int guard;
        int i;
        bit rr;
        logic [31:0] exp;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL rd_start_ready addr=%h: got %b want 1", addr, req_ready);
        end
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = addr;
        @(negedge clk);
        req_valid = hold;
        req_write = 1'($urandom_range(0, 1));
        req_addr  = $urandom();
        k = 0;
        while (rvalid !== 1'b1 && k < 4 * LAT + 8) begin
            checks++;
            if (busy !== 1'b1 || req_ready !== 1'b0 || wready !== 1'b0) begin
                errors++;
                $display("FAIL rd_wait addr=%h: busy=%b req_ready=%b wready=%b want 1,0,0",
                         addr, busy, req_ready, wready);
            end
            @(negedge clk);
            k++;
        end
        checks++;
        if (k != LAT) begin
            errors++;
            $display("FAIL rd_latency addr=%h: got %0d want %0d", addr, k, LAT);
        end
        b = 0;
        guard = 0;
        i = 0;
        while (b < LW && guard < 64) begin
            case (mode)
                0:       rr = 1'b1;
                1:       rr = 1'($urandom_range(0, 1));
                default: rr = (i < 7) ? stall_pat[i] : 1'b1;
            endcase
            rready = rr;
            i++;
            exp = ref_mem[widx(addr, b)];
            checks++;
            if (rvalid !== 1'b1 || rdata !== exp || rlast !== (b == LW - 1) || req_ready !== 1'b0) begin
                errors++;
                $display("FAIL rd_beat addr=%h beat=%0d: rvalid=%b rdata=%h rlast=%b req_ready=%b want 1,%h,%b,0",
                         addr, b, rvalid, rdata, rlast, req_ready, exp, (b == LW - 1));
            end
            @(negedge clk);
            guard++;
            if (rr) b++;
        end
        rready = 1'($urandom_range(0, 1));
        checks++;
        if (b != LW) begin
            errors++;
            $display("FAIL rd_beats addr=%h: got %0d want %0d", addr, b, LW);
        end
        checks++;
        if (rvalid !== 1'b0 || rlast !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rd_end addr=%h: rvalid=%b rlast=%b req_ready=%b busy=%b want 0,0,1,0",
                     addr, rvalid, rlast, req_ready, busy);
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 32'h100;
        wvalid    = 1'b1;
        rready    = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || rvalid !== 1'b0 || rlast !== 1'b0 || wready !== 1'b0 ||
            wdone !== 1'b0 || rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs: busy=%b rvalid=%b rlast=%b wready=%b wdone=%b rdata=%h want all 0",
                     busy, rvalid, rlast, wready, wdone, rdata);
        end
        rst       = 1'b0;
        req_valid = 1'b0;
        wvalid    = 1'b0;
        rready    = 1'b0;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: req_ready=%b busy=%b want 1,0", req_ready, busy);
        end
    endtask

    task automatic test_fill();
        logic [31:0] d [LW];
        logic [31:0] a;
        for (int line = 0; line < WORDS / LW; line++) begin
            for (int j = 0; j < LW; j++) d[j] = $urandom();
            a = $urandom();
            a[MWL+1:0] = {10'(line), 4'($urandom_range(0, 15))};
            write_line(a, d, 1'b1);
        end
    endtask

    task automatic test_writeback_basic();
        logic [31:0] d [LW];
        d = '{32'h11, 32'h22, 32'h33, 32'h44};
        write_line(32'h100, d, 1'b0);
    endtask

    task automatic test_refill_basic();
        read_line(32'h10C, 0, 1'b0);
        checks++;
        if (ref_mem[widx(32'h10C, 3)] !== 32'h44) begin
            errors++;
            $display("FAIL refill_model_word: got %h want 00000044", ref_mem[widx(32'h10C, 3)]);
        end
    endtask

    task automatic test_refill_stall();
        read_line(32'h104, 2, 1'b0);
        read_line(32'h2F0, 1, 1'b0);
    endtask

    task automatic test_alias();
        logic [31:0] d [LW];
        for (int j = 0; j < LW; j++) d[j] = $urandom();
        write_line(32'h1100, d, 1'b1);
        read_line(32'h100, 0, 1'b0);
    endtask

    task automatic test_reset_mid_write();
        logic [31:0] d [LW];
        int k;
        for (int j = 0; j < LW; j++) d[j] = $urandom();
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 32'h200;
        @(negedge clk);
        req_valid = 1'b0;
        k = 0;
        while (wready !== 1'b1 && k < 4 * LAT + 8) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (k != LAT) begin
            errors++;
            $display("FAIL rstw_latency: got %0d want %0d", k, LAT);
        end
        for (int b = 0; b < 2; b++) begin
            wvalid = 1'b1;
            wdata  = d[b];
            @(negedge clk);
            ref_mem[widx(32'h200, b)] = d[b];
        end
        rst    = 1'b1;
        wvalid = 1'b1;
        wdata  = d[2];
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || wdone !== 1'b0 || wready !== 1'b0) begin
            errors++;
            $display("FAIL rstw_abort: busy=%b wdone=%b wready=%b want 0,0,0", busy, wdone, wready);
        end
        rst    = 1'b0;
        wvalid = 1'b0;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1 || wdone !== 1'b0) begin
            errors++;
            $display("FAIL rstw_idle: req_ready=%b wdone=%b want 1,0", req_ready, wdone);
        end
        read_line(32'h200, 0, 1'b0);
    endtask

    task automatic test_back_to_back();
        read_line(32'h340, 0, 1'b1);
        read_line(32'h7A8, 1, 1'b1);
        read_line(32'h100, 2, 1'b0);
    endtask

    task automatic test_random();
        logic [31:0] d [LW];
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 1) == 1) begin
                for (int j = 0; j < LW; j++) d[j] = $urandom();
                write_line($urandom(), d, 1'b1);
            end else begin
                read_line($urandom(), 1, 1'($urandom_range(0, 1)) && (n != 59));
            end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_fill();
        test_writeback_basic();
        test_refill_basic();
        test_refill_stall();
        test_alias();
        test_reset_mid_write();
        test_back_to_back();
        test_random();
        req_valid = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
